// File: rtl/i2c_sensor_sequencer.sv
// i2c_sensor_sequencer: configures an I2C temperature-style sensor once per start,
// then periodically reads a 16-bit sample via two pointer-write/byte-read pairs.
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   start              level; 1 runs config then polling, 0 stops at the next safe point
//   i2c_addr/data_in/rw/enable   request side of the I2C controller handshake
//   i2c_ready/data_out           controller idle flag (async to clk) and read byte
//   sample/sample_valid          last {msb,lsb} reading and its one-cycle update strobe
//   busy, error                  activity flag and sticky timeout flag
module i2c_sensor_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter logic [7:0]  CFG_VALUE   = 8'h60,
    parameter logic [7:0]  PTR_MSB     = 8'h00,
    parameter logic [7:0]  PTR_LSB     = 8'h01,
    parameter int unsigned POLL_PERIOD = 100000,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [6:0]  i2c_addr,
    output logic [7:0]  i2c_data_in,
    output logic        i2c_rw,
    output logic        i2c_enable,
    input  logic        i2c_ready,
    input  logic [7:0]  i2c_data_out,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        error
);

    localparam int unsigned PER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(POLL_PERIOD - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_POLL_WAIT, S_WR_PMSB, S_RD_MSB,
        S_WR_PLSB, S_RD_LSB, S_DONE, S_ERR
    } state_t;

    typedef enum logic {PH_REQ, PH_WAIT} phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic [TMO_W-1:0] phase_cnt, phase_cnt_n;
    logic [PER_W-1:0] period_cnt, period_cnt_n;
    logic [7:0]       msb_q, msb_n;
    logic [7:0]       data_n;
    logic             rw_n;
    logic             enable_n;
    logic [15:0]      sample_n;
    logic             sample_valid_n;
    logic             busy_n;
    logic             error_n;
    logic             enter;
    logic             ready_m, ready_s;

    // Two-flop synchronizer for the controller idle flag; idle is the safe reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_m <= 1'b1;
            ready_s <= 1'b1;
        end else begin
            ready_m <= i2c_ready;
            ready_s <= ready_m;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            phase        <= PH_REQ;
            phase_cnt    <= '0;
            period_cnt   <= '0;
            msb_q        <= '0;
            i2c_addr     <= DEV_ADDR;
            i2c_data_in  <= '0;
            i2c_rw       <= 1'b0;
            i2c_enable   <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            phase_cnt    <= phase_cnt_n;
            period_cnt   <= period_cnt_n;
            msb_q        <= msb_n;
            i2c_addr     <= DEV_ADDR;
            i2c_data_in  <= data_n;
            i2c_rw       <= rw_n;
            i2c_enable   <= enable_n;
            sample       <= sample_n;
            sample_valid <= sample_valid_n;
            busy         <= busy_n;
            error        <= error_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n        = state;
        phase_n        = phase;
        // Both counters saturate so they can never wrap before their terminal count.
        phase_cnt_n    = (phase_cnt == TMO_LAST) ? phase_cnt : phase_cnt + TMO_W'(1);
        period_cnt_n   = (period_cnt == PER_LAST) ? period_cnt : period_cnt + PER_W'(1);
        msb_n          = msb_q;
        data_n         = i2c_data_in;
        rw_n           = i2c_rw;
        sample_n       = sample;
        sample_valid_n = 1'b0;
        error_n        = error;
        enter          = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n      = S_CFG;
                    error_n      = 1'b0;
                    period_cnt_n = '0;
                end
            end
            S_CFG, S_WR_PMSB, S_RD_MSB, S_WR_PLSB, S_RD_LSB: begin
                if (phase == PH_REQ) begin
                    if (!ready_s) begin
                        phase_n     = PH_WAIT;
                        phase_cnt_n = '0;
                    end else if (phase_cnt == TMO_LAST) begin
                        state_n = S_ERR;
                    end
                end else if (ready_s) begin
                    case (state)
                        S_CFG:     state_n = S_POLL_WAIT;
                        S_WR_PMSB: state_n = S_RD_MSB;
                        S_RD_MSB: begin
                            msb_n   = i2c_data_out;
                            state_n = S_WR_PLSB;
                        end
                        S_WR_PLSB: state_n = S_RD_LSB;
                        S_RD_LSB: begin
                            sample_n       = {msb_q, i2c_data_out};
                            sample_valid_n = 1'b1;
                            state_n        = S_DONE;
                        end
                        default:   state_n = S_IDLE;
                    endcase
                end else if (phase_cnt == TMO_LAST) begin
                    state_n = S_ERR;
                end
            end
            S_POLL_WAIT: begin
                if (!start) begin
                    state_n = S_IDLE;
                end else if (period_cnt == PER_LAST) begin
                    state_n = S_WR_PMSB;
                end
            end
            S_DONE: state_n = start ? S_POLL_WAIT : S_IDLE;
            S_ERR: begin
                if (ready_s && !start) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_n == S_ERR && state != S_ERR) begin
            error_n = 1'b1;
        end

        // Entering any transaction state starts a fresh REQ phase with stable request fields.
        enter = (state_n != state) &&
                (state_n inside {S_CFG, S_WR_PMSB, S_RD_MSB, S_WR_PLSB, S_RD_LSB});
        if (enter) begin
            phase_n     = PH_REQ;
            phase_cnt_n = '0;
            case (state_n)
                S_CFG: begin
                    data_n = CFG_VALUE;
                    rw_n   = 1'b0;
                end
                S_WR_PMSB: begin
                    data_n       = PTR_MSB;
                    rw_n         = 1'b0;
                    period_cnt_n = '0;
                end
                S_WR_PLSB: begin
                    data_n = PTR_LSB;
                    rw_n   = 1'b0;
                end
                default: begin
                    data_n = 8'h00;
                    rw_n   = 1'b1;
                end
            endcase
        end

        enable_n = (state_n inside {S_CFG, S_WR_PMSB, S_RD_MSB, S_WR_PLSB, S_RD_LSB}) &&
                   (phase_n == PH_REQ);
        busy_n   = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_i2c_sensor_sequencer.sv
// Testbench for i2c_sensor_sequencer: an asynchronous I2C controller model on its own
// clock (about 4x faster than clk) logs every accepted request and returns random read
// bytes; expectations come from the transaction pattern and the returned bytes.
module tb_i2c_sensor_sequencer;

    localparam logic [6:0] DEV  = 7'h48;
    localparam logic [7:0] CFGV = 8'h60;
    localparam logic [7:0] PMSB = 8'h00;
    localparam logic [7:0] PLSB = 8'h01;
    localparam int         PER  = 200;
    localparam int         TMO  = 16;

    typedef struct packed {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] data;
    } xact_t;

    logic        clk = 1'b0;
    logic        ctl_clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data_in;
    logic        i2c_rw;
    logic        i2c_enable;
    logic        i2c_ready = 1'b1;
    logic [7:0]  i2c_data_out = 8'h00;
    logic [15:0] sample;
    logic        sample_valid;
    logic        busy;
    logic        error;

    xact_t       acc_q[$];
    logic [7:0]  ret_q[$];
    logic [7:0]  force_q[$];
    logic [15:0] sv_q[$];
    int          pmsb_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sv_long = 0;
    bit sv_prev = 1'b0;
    bit en_prev = 1'b0;
    bit stuck = 1'b0;

    int         ctl_busy = 0;
    logic       ctl_rd = 1'b0;
    logic [7:0] ctl_byte = 8'h00;

    i2c_sensor_sequencer #(
        .DEV_ADDR   (DEV),
        .CFG_VALUE  (CFGV),
        .PTR_MSB    (PMSB),
        .PTR_LSB    (PLSB),
        .POLL_PERIOD(PER),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .i2c_addr    (i2c_addr),
        .i2c_data_in (i2c_data_in),
        .i2c_rw      (i2c_rw),
        .i2c_enable  (i2c_enable),
        .i2c_ready   (i2c_ready),
        .i2c_data_out(i2c_data_out),
        .sample      (sample),
        .sample_valid(sample_valid),
        .busy        (busy),
        .error       (error)
    );

    always #21 clk = ~clk;
    always #5 ctl_clk = ~ctl_clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: accept when idle and requested, stay busy 16..24 of its cycles,
    // present garbage on data_out while busy and the real byte only at completion.
    always @(posedge ctl_clk) begin
        if (ctl_busy != 0) begin
            ctl_busy = ctl_busy - 1;
            if (ctl_busy == 0) begin
                if (ctl_rd) begin
                    i2c_data_out = ctl_byte;
                    ret_q.push_back(ctl_byte);
                end
                i2c_ready = 1'b1;
            end
        end else if (!stuck && i2c_ready && i2c_enable) begin
            acc_q.push_back({i2c_addr, i2c_rw, i2c_data_in});
            ctl_rd = i2c_rw;
            if (i2c_rw) begin
                if (force_q.size() > 0) ctl_byte = force_q.pop_front();
                else ctl_byte = 8'($urandom);
            end
            i2c_data_out = 8'($urandom);
            ctl_busy = int'($urandom_range(24, 16));
            i2c_ready = 1'b0;
        end
    end

    // Output monitor: sample strobes, strobe width, and WR_PMSB request start times.
    always @(negedge clk) begin
        if (sample_valid) begin
            sv_q.push_back(sample);
            if (sv_prev) sv_long = sv_long + 1;
        end
        sv_prev = sample_valid;
        if (i2c_enable && !en_prev && !i2c_rw && i2c_data_in == PMSB) pmsb_q.push_back(cyc);
        en_prev = i2c_enable;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, observed t=%0t expected completion", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        int k = 0;
        while (acc_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(acc_q.size() >= n), 32'd1);
    endtask

    task automatic wait_sv(input int n, input int budget, input string tag);
        int k = 0;
        while (sv_q.size() < n && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(sv_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_en(input logic val, input int budget, input string tag);
        int k = 0;
        while (i2c_enable !== val && k < budget) begin @(negedge clk); k++; end
        chk(tag, 32'(i2c_enable), 32'(val));
    endtask

    task automatic clear_logs();
        acc_q.delete();
        ret_q.delete();
        sv_q.delete();
        pmsb_q.delete();
    endtask

    // Expected i-th request after a start: one config write, then 4 requests per poll.
    function automatic xact_t exp_x(input int i);
        if (i == 0) return {DEV, 1'b0, CFGV};
        case ((i - 1) % 4)
            0:       return {DEV, 1'b0, PMSB};
            1:       return {DEV, 1'b1, 8'h00};
            2:       return {DEV, 1'b0, PLSB};
            default: return {DEV, 1'b1, 8'h00};
        endcase
    endfunction

    // Every complete run must show exactly CFG + 4 requests per sample, and each sample
    // must equal the two bytes the controller returned for that poll.
    task automatic verify_run(input string tag);
        xact_t o;
        xact_t e;
        chk({tag, "_log_len"}, 32'(acc_q.size()), 32'(1 + 4 * sv_q.size()));
        for (int i = 0; i < acc_q.size(); i++) begin
            o = acc_q[i];
            e = exp_x(i);
            if (e.rw) o.data = 8'h00;
            chk({tag, "_xact"}, 32'(o), 32'(e));
        end
        for (int p = 0; p < sv_q.size(); p++) begin
            chk({tag, "_sample"}, 32'(sv_q[p]), 32'({ret_q[2 * p], ret_q[2 * p + 1]}));
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_enable"}, 32'(i2c_enable), 32'd0);
        chk({tag, "_rw"}, 32'(i2c_rw), 32'd0);
        chk({tag, "_addr"}, 32'(i2c_addr), 32'(DEV));
        chk({tag, "_data_in"}, 32'(i2c_data_in), 32'd0);
        chk({tag, "_sample"}, 32'(sample), 32'd0);
        chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [15:0] last_sample;
        int          n;
        int          cfg_cnt;

        // Reset state
        #30;
        chk_reset_vals("por");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // Single poll with fixed bytes, then 3 more polls for period checking
        force_q.push_back(8'h12);
        force_q.push_back(8'h34);
        start = 1'b1;
        wait_sv(1, 600, "first_sample_wait");
        chk("first_sample", 32'(sv_q[0]), 32'h1234);
        chk("sample_hold", 32'(sample), 32'h1234);
        wait_sv(4, 1000, "poll3_wait");
        start = 1'b0;
        wait_idle(400, "poll3_idle");
        verify_run("poll3");
        cfg_cnt = 0;
        foreach (acc_q[i]) if (!acc_q[i].rw && acc_q[i].data == CFGV) cfg_cnt++;
        chk("cfg_once", 32'(cfg_cnt), 32'd1);
        chk("pmsb_count", 32'(pmsb_q.size() >= 4), 32'd1);
        for (int k = 1; k < pmsb_q.size(); k++) begin
            chk("poll_period", 32'(pmsb_q[k] - pmsb_q[k - 1]), 32'(PER));
        end

        // Long run of random bytes over the asynchronous handshake
        clear_logs();
        start = 1'b1;
        wait_sv(50, 50 * PER + 800, "poll50_wait");
        start = 1'b0;
        wait_idle(400, "poll50_idle");
        verify_run("poll50");

        // Drop start while RD_MSB is in flight: the poll still completes
        clear_logs();
        start = 1'b1;
        wait_acc(3, 600, "rdmsb_wait");
        start = 1'b0;
        wait_idle(400, "stop_idle");
        chk("stop_log_len", 32'(acc_q.size()), 32'd5);
        chk("stop_sv_count", 32'(sv_q.size()), 32'd1);
        verify_run("stop");

        // Reset during the WAIT phase of WR_PLSB
        clear_logs();
        start = 1'b1;
        wait_acc(4, 600, "wrplsb_wait");
        wait_en(1'b0, 20, "wrplsb_wait_phase");
        #2 rst = 1'b0;
        #1 chk_reset_vals("midreset");
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_enable", 32'(i2c_enable), 32'd0);
        clear_logs();
        start = 1'b1;
        wait_acc(1, 50, "restart_wait");
        chk("restart_cfg", 32'(acc_q[0]), 32'({DEV, 1'b0, CFGV}));
        wait_sv(1, 600, "restart_sample_wait");
        start = 1'b0;
        wait_idle(400, "restart_idle");
        verify_run("restart");

        // Timeout: controller never accepts
        last_sample = sample;
        stuck = 1'b1;
        start = 1'b1;
        wait_en(1'b1, 20, "tmo_enable");
        n = 0;
        while (error !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_enable_low", 32'(i2c_enable), 32'd0);
        chk("tmo_sample_kept", 32'(sample), 32'(last_sample));
        chk("tmo_busy", 32'(busy), 32'd1);
        stuck = 1'b0;
        start = 1'b0;
        wait_idle(50, "err_idle");
        chk("error_sticky", 32'(error), 32'd1);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("error_cleared", 32'(error), 32'd0);
        start = 1'b0;
        wait_idle(600, "final_idle");

        chk("strobe_width", 32'(sv_long), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
